// File: rtl/sprite_fetch_sched.sv
// Sprite fetch sequencer: walks the 8 sprite-temp slots once per scanline,
// fetches both pattern planes for each valid slot and emits one shifter load
// word per slot (empty slots get a transparent word with X = 8'hFF).
module sprite_fetch_sched (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_line_start,
    input  logic [3:0]  i_sprite_count,
    input  logic        i_obj_size,
    input  logic        i_spr_table,
    output logic [4:0]  o_stemp_addr,
    input  logic [7:0]  i_stemp_data,
    output logic        o_pat_req,
    output logic [12:0] o_pat_addr,
    input  logic        i_pat_ack,
    input  logic [7:0]  i_pat_data,
    output logic [3:0]  o_load,
    output logic [26:0] o_load_data,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned RD_W    = 3;
    localparam int unsigned PADDR_W = 13;
    localparam int unsigned WORD_W  = 27;

    localparam logic [CNT_W-1:0]  MAX_SLOTS  = CNT_W'(8);
    localparam logic [RD_W-1:0]   RD_LAST    = RD_W'(4);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(7);
    localparam logic [WORD_W-1:0] EMPTY_WORD = {8'h00, 8'h00, 8'hFF, 2'b00, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_FLO,
        S_FHI,
        S_LOAD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [RD_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [3:0]          row_q, row_d;
    logic [7:0]          tile_q, tile_d;
    logic                vflip_q, vflip_d;
    logic                hflip_q, hflip_d;
    logic                prio_q, prio_d;
    logic [1:0]          pal_q, pal_d;
    logic [7:0]          x_q, x_d;
    logic [7:0]          lo_q, lo_d;

    logic [4:0]          stemp_addr_q, stemp_addr_d;
    logic                pat_req_q, pat_req_d;
    logic [PADDR_W-1:0]  pat_addr_q, pat_addr_d;
    logic [3:0]          load_q, load_d;
    logic [WORD_W-1:0]   load_data_q, load_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          row_eff_c;
    logic [PADDR_W-1:0]  addr_lo_c, addr_hi_c;

    // The shifter emits bit 0 first, so unflipped sprites are stored reversed.
    function automatic logic [7:0] shifter_order(input logic [7:0] b, input logic hflip);
        logic [7:0] rev;
        for (int i = 0; i < 8; i++) begin
            rev[i] = b[7-i];
        end
        return hflip ? b : rev;
    endfunction

    // Pattern addresses for both planes of the current slot.
    always_comb begin
        row_eff_c = row_q;
        if (vflip_q) begin
            row_eff_c = (i_obj_size ? 4'd15 : 4'd7) - row_q;
        end
        if (i_obj_size) begin
            addr_lo_c = {tile_q[0], tile_q[7:1], row_eff_c[3], 1'b0, row_eff_c[2:0]};
            addr_hi_c = {tile_q[0], tile_q[7:1], row_eff_c[3], 1'b1, row_eff_c[2:0]};
        end else begin
            addr_lo_c = {i_spr_table, tile_q, 1'b0, row_eff_c[2:0]};
            addr_hi_c = {i_spr_table, tile_q, 1'b1, row_eff_c[2:0]};
        end
    end

    // Next state, slot bookkeeping and the next value of every registered output.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        n_d          = n_q;
        rd_cnt_d     = rd_cnt_q;
        row_d        = row_q;
        tile_d       = tile_q;
        vflip_d      = vflip_q;
        hflip_d      = hflip_q;
        prio_d       = prio_q;
        pal_d        = pal_q;
        x_d          = x_q;
        lo_d         = lo_q;
        stemp_addr_d = stemp_addr_q;
        pat_addr_d   = pat_addr_q;
        load_data_d  = load_data_q;
        pat_req_d    = 1'b0;
        load_d       = 4'h0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_line_start) begin
                    n_d    = (i_sprite_count > MAX_SLOTS) ? MAX_SLOTS : i_sprite_count;
                    slot_d = '0;
                    if (n_d != '0) begin
                        state_d  = S_RD;
                        rd_cnt_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_RD: begin
                rd_cnt_d = rd_cnt_q + RD_W'(1);
                unique case (rd_cnt_q)
                    RD_W'(1): row_d = i_stemp_data[3:0];
                    RD_W'(2): tile_d = i_stemp_data;
                    RD_W'(3): begin
                        vflip_d = i_stemp_data[7];
                        hflip_d = i_stemp_data[6];
                        prio_d  = i_stemp_data[5];
                        pal_d   = i_stemp_data[1:0];
                    end
                    RD_W'(4): x_d = i_stemp_data;
                    default: ;
                endcase
                if (rd_cnt_q == RD_LAST) begin
                    state_d = S_FLO;
                end
            end
            S_FLO: begin
                if (i_pat_ack) begin
                    lo_d    = shifter_order(i_pat_data, hflip_q);
                    state_d = S_FHI;
                end
            end
            S_FHI: begin
                if (i_pat_ack) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = S_DONE;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                    if (CNT_W'(slot_q) + CNT_W'(1) < n_q) begin
                        state_d  = S_RD;
                        rd_cnt_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs describe the state being entered.
        if (state_d == S_RD && rd_cnt_d < RD_LAST) begin
            stemp_addr_d = {slot_d, rd_cnt_d[1:0]};
        end
        pat_req_d = (state_d == S_FLO) || (state_d == S_FHI);
        if (state_d == S_FLO && state_q != S_FLO) begin
            pat_addr_d = addr_lo_c;
        end
        if (state_d == S_FHI && state_q != S_FHI) begin
            pat_addr_d = addr_hi_c;
        end
        if (state_d == S_LOAD) begin
            load_d = 4'hF;
            if (state_q == S_FHI) begin
                load_data_d = {lo_q, shifter_order(i_pat_data, hflip_q), x_q, pal_q, prio_q};
            end else begin
                load_data_d = EMPTY_WORD;
            end
        end
        busy_d = (state_d == S_RD) || (state_d == S_FLO) ||
                 (state_d == S_FHI) || (state_d == S_LOAD);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset abandons any pass in flight.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            n_q          <= '0;
            rd_cnt_q     <= '0;
            row_q        <= '0;
            tile_q       <= '0;
            vflip_q      <= 1'b0;
            hflip_q      <= 1'b0;
            prio_q       <= 1'b0;
            pal_q        <= '0;
            x_q          <= '0;
            lo_q         <= '0;
            stemp_addr_q <= '0;
            pat_req_q    <= 1'b0;
            pat_addr_q   <= '0;
            load_q       <= '0;
            load_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            n_q          <= n_d;
            rd_cnt_q     <= rd_cnt_d;
            row_q        <= row_d;
            tile_q       <= tile_d;
            vflip_q      <= vflip_d;
            hflip_q      <= hflip_d;
            prio_q       <= prio_d;
            pal_q        <= pal_d;
            x_q          <= x_d;
            lo_q         <= lo_d;
            stemp_addr_q <= stemp_addr_d;
            pat_req_q    <= pat_req_d;
            pat_addr_q   <= pat_addr_d;
            load_q       <= load_d;
            load_data_q  <= load_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_stemp_addr = stemp_addr_q;
    assign o_pat_req    = pat_req_q;
    assign o_pat_addr   = pat_addr_q;
    assign o_load       = load_q;
    assign o_load_data  = load_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
